cg_dot_product_unit: RTL



---
 rtl/cg_pkg.sv | 25 ++
 rtl/cg_dot_adder_tree.sv | 36 +++
 rtl/cg_dot_product_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cg_pkg.sv
// Shared defaults, FSM state encoding and lane helper for the CG dot-product datapath.
package cg_pkg;

  localparam int unsigned NO_OF_UNITS   = 8;
  localparam int unsigned ELEMENT_WIDTH = 32;
  localparam int unsigned FRAC_BITS     = 16;
  localparam int unsigned ACC_WIDTH     = 64;
  localparam int unsigned ROWS          = 3;
  localparam int unsigned ADDR_WIDTH    = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [ELEMENT_WIDTH-1:0] lane_slice(
    input logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] row,
    input int unsigned                          idx
  );
    return row[idx*ELEMENT_WIDTH +: ELEMENT_WIDTH];
  endfunction

endpackage

// File: rtl/cg_dot_adder_tree.sv
// Registered NO_OF_UNITS-input sum of ACC_WIDTH lanes (one pipeline stage), wrap-around arithmetic.
module cg_dot_adder_tree #(
  parameter int unsigned NO_OF_UNITS = 8,
  parameter int unsigned ACC_WIDTH   = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            in_valid,
  input  logic [NO_OF_UNITS*ACC_WIDTH-1:0] in_data,
  output logic                            out_valid,
  output logic [ACC_WIDTH-1:0]            out_sum
);

  logic [ACC_WIDTH-1:0] sum_d;

  always_comb begin
    sum_d = '0;
    for (int unsigned i = 0; i < NO_OF_UNITS; i++) begin
      sum_d = sum_d + in_data[i*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_sum <= sum_d;
      end
    end
  end

endmodule

// File: rtl/cg_dot_product_unit.sv
// Streaming fixed-point dot product over ROWS memory rows; optional result saturation
// enabled by defining VDOT_SAT_EN (otherwise result wraps and ovf is tied low).
module cg_dot_product_unit
  import cg_pkg::*;
#(
  parameter int unsigned NO_OF_UNITS   = cg_pkg::NO_OF_UNITS,
  parameter int unsigned ELEMENT_WIDTH = cg_pkg::ELEMENT_WIDTH,
  parameter int unsigned FRAC_BITS     = cg_pkg::FRAC_BITS,
  parameter int unsigned ACC_WIDTH     = cg_pkg::ACC_WIDTH,
  parameter int unsigned ROWS          = cg_pkg::ROWS,
  parameter int unsigned ADDR_WIDTH    = cg_pkg::ADDR_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 abort,
  output logic                                 rd_en,
  output logic [ADDR_WIDTH-1:0]                rd_addr,
  input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] row_a,
  input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] row_b,
  output logic                                 busy,
  output logic                                 done,
  output logic [ELEMENT_WIDTH-1:0]             result,
  output logic                                 ovf
);

  localparam int unsigned PW = 2 * ELEMENT_WIDTH;

  state_t state_q, state_d;

  logic                             start_ok, pipe_clear, last_addr;
  logic                             d_valid_q, p_valid_q, s_valid;
  logic [NO_OF_UNITS*ACC_WIDTH-1:0] prod_d, prod_q;
  logic signed [ELEMENT_WIDTH-1:0]  op_a, op_b;
  logic signed [PW-1:0]             prod_full;
  logic [ACC_WIDTH-1:0]             tree_sum, acc_q;
  logic [ELEMENT_WIDTH-1:0]         result_q, result_now;

  assign start_ok   = (state_q == IDLE) && start && !abort;
  assign pipe_clear = abort || start_ok;
  assign last_addr  = (rd_addr == ADDR_WIDTH'(ROWS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = READ;
      READ:    if (last_addr) state_d = DRAIN;
      // last tree sum is being accumulated when S0 and S1 are both empty
      DRAIN:   if (!d_valid_q && !p_valid_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rd_addr <= '0;
    end else begin
      state_q <= state_d;
      if (abort) begin
        rd_addr <= '0;
      end else if (state_q == READ) begin
        rd_addr <= last_addr ? '0 : rd_addr + 1'b1;
      end
    end
  end

  assign rd_en = (state_q == READ);
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);

  always_comb begin
    prod_d    = '0;
    op_a      = '0;
    op_b      = '0;
    prod_full = '0;
    for (int unsigned i = 0; i < NO_OF_UNITS; i++) begin
      op_a      = signed'(lane_slice(row_a, i));
      op_b      = signed'(lane_slice(row_b, i));
      prod_full = PW'(op_a) * PW'(op_b);
      prod_d[i*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(prod_full >>> FRAC_BITS);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || pipe_clear) begin
      d_valid_q <= 1'b0;
      p_valid_q <= 1'b0;
    end else begin
      d_valid_q <= rd_en;
      p_valid_q <= d_valid_q;
    end
    if (d_valid_q) begin
      prod_q <= prod_d;
    end
  end

  cg_dot_adder_tree #(
    .NO_OF_UNITS (NO_OF_UNITS),
    .ACC_WIDTH   (ACC_WIDTH)
  ) u_tree (
    .clk       (clk),
    .reset     (reset),
    .clear     (pipe_clear),
    .in_valid  (p_valid_q),
    .in_data   (prod_q),
    .out_valid (s_valid),
    .out_sum   (tree_sum)
  );

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      acc_q <= '0;
    end else if (s_valid && !abort) begin
      acc_q <= acc_q + tree_sum;
    end
  end

`ifdef VDOT_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    signed'({{(ACC_WIDTH-ELEMENT_WIDTH+1){1'b0}}, {(ELEMENT_WIDTH-1){1'b1}}});
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  logic ovf_now, ovf_q;

  always_comb begin
    ovf_now    = 1'b0;
    result_now = acc_q[ELEMENT_WIDTH-1:0];
    if (signed'(acc_q) > SAT_MAX) begin
      ovf_now    = 1'b1;
      result_now = SAT_MAX[ELEMENT_WIDTH-1:0];
    end else if (signed'(acc_q) < SAT_MIN) begin
      ovf_now    = 1'b1;
      result_now = SAT_MIN[ELEMENT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      ovf_q <= 1'b0;
    end else if (done) begin
      ovf_q <= ovf_now;
    end
  end

  assign ovf = done ? ovf_now : ovf_q;
`else
  assign result_now = acc_q[ELEMENT_WIDTH-1:0];
  assign ovf        = 1'b0;
`endif

  // result is live in the DONE cycle and latched so later aborts cannot disturb it
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
    end else if (done) begin
      result_q <= result_now;
    end
  end

  assign result = done ? result_now : result_q;

endmodule
